// File: rtl/measurement_sequencer_if.sv
// Control/status bundle for the measurement sequencer: the requester side (master)
// supplies start/abort and configuration; the sequencer side (slave) drives light and counter controls.
interface measurement_sequencer_if;
  logic        start;
  logic        abort;
  logic [31:0] half_period;
  logic [15:0] num_cycles;
  logic [15:0] settle_clks;
  logic        light_source_pin;
  logic        count_on_en;
  logic        count_off_en;
  logic        counter_clear;
  logic        result_latch;
  logic        busy;
  logic        done;
  logic [15:0] cycle_index;

  modport master (
    output start, abort, half_period, num_cycles, settle_clks,
    input  light_source_pin, count_on_en, count_off_en, counter_clear,
           result_latch, busy, done, cycle_index
  );

  modport slave (
    input  start, abort, half_period, num_cycles, settle_clks,
    output light_source_pin, count_on_en, count_off_en, counter_clear,
           result_latch, busy, done, cycle_index
  );
endinterface

// File: rtl/measurement_sequencer.sv
// Lock-in style light on/off sequencer driving photon counter buckets; start->clear 1 clk, light 2 clks.
// No backpressure; outputs registered. SEQ_DARK_PHASE_EN adds a 2*half_period dark phase before the first ON.
module measurement_sequencer (
  input  logic                         clock_50_mhz,
  input  logic                         reset,
  measurement_sequencer_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
`ifdef SEQ_DARK_PHASE_EN
    S_DARK,
`endif
    S_ON,
    S_OFF,
    S_LATCH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] hp_q, hp_d;
  logic [15:0] nc_q, nc_d;
  logic [15:0] st_q, st_d;
  logic        light_q, light_d;
  logic        on_en_q, on_en_d;
  logic        off_en_q, off_en_d;
  logic        clear_q, clear_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef SEQ_DARK_PHASE_EN
  logic        dark_half_q, dark_half_d;
`endif

  logic phase_end;
  logic last_pair;
  logic in_run;

  assign phase_end = (timer_q == hp_q - 32'd1);
  assign last_pair = (idx_q == nc_q - 16'd1);
  assign in_run    = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    hp_d    = hp_q;
    nc_d    = nc_q;
    st_d    = st_q;
`ifdef SEQ_DARK_PHASE_EN
    dark_half_d = dark_half_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          timer_d = '0;
          if (bus.abort) begin
            state_d = S_IDLE;
          end else begin
            hp_d    = (bus.half_period == 32'd0) ? 32'd1 : bus.half_period;
            nc_d    = (bus.num_cycles == 16'd0) ? 16'd1 : bus.num_cycles;
            st_d    = bus.settle_clks;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        timer_d = '0;
`ifdef SEQ_DARK_PHASE_EN
        dark_half_d = 1'b0;
        state_d     = S_DARK;
`else
        state_d = S_ON;
`endif
      end
`ifdef SEQ_DARK_PHASE_EN
      // Dark spans two half-periods; the flag avoids a 33-bit timer.
      S_DARK: begin
        timer_d = timer_q + 32'd1;
        if (phase_end) begin
          timer_d     = '0;
          dark_half_d = 1'b1;
          if (dark_half_q) begin
            dark_half_d = 1'b0;
            state_d     = S_ON;
          end
        end
      end
`endif
      S_ON: begin
        timer_d = timer_q + 32'd1;
        if (phase_end) begin
          timer_d = '0;
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        timer_d = timer_q + 32'd1;
        if (phase_end) begin
          timer_d = '0;
          if (last_pair) begin
            state_d = S_LATCH;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_ON;
          end
        end
      end
      S_LATCH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && in_run) begin
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
`ifdef SEQ_DARK_PHASE_EN
      dark_half_d = 1'b0;
`endif
    end

    // Outputs are decoded from next-state values so they appear registered with no extra lag.
    light_d  = (state_d == S_ON);
    on_en_d  = (state_d == S_ON) && (timer_d >= {16'd0, st_d});
    off_en_d = (state_d == S_OFF) && (timer_d >= {16'd0, st_d});
`ifdef SEQ_DARK_PHASE_EN
    if (state_d == S_DARK) begin
      off_en_d = (({1'b0, timer_d} + (dark_half_d ? {1'b0, hp_d} : 33'd0)) >= {17'd0, st_d});
    end
`endif
    clear_d  = (state_d == S_CLEAR);
    latch_d  = (state_d == S_LATCH);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      hp_q     <= '0;
      nc_q     <= '0;
      st_q     <= '0;
      light_q  <= 1'b0;
      on_en_q  <= 1'b0;
      off_en_q <= 1'b0;
      clear_q  <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_DARK_PHASE_EN
      dark_half_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      hp_q     <= hp_d;
      nc_q     <= nc_d;
      st_q     <= st_d;
      light_q  <= light_d;
      on_en_q  <= on_en_d;
      off_en_q <= off_en_d;
      clear_q  <= clear_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQ_DARK_PHASE_EN
      dark_half_q <= dark_half_d;
`endif
    end
  end

  assign bus.light_source_pin = light_q;
  assign bus.count_on_en      = on_en_q;
  assign bus.count_off_en     = off_en_q;
  assign bus.counter_clear    = clear_q;
  assign bus.result_latch     = latch_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.cycle_index      = idx_q;

endmodule
